// File: rtl/vit_pkg.sv
// Shared image/patch geometry for the ViT front end, plus the streamer FSM encoding.
package vit_pkg;
  localparam int CHANNEL_SIZE      = 8;
  localparam int NUM_CHANNELS      = 3;
  localparam int IMG_WIDTH         = 16;
  localparam int IMG_HEIGHT        = 16;
  localparam int PATCH_SIZE        = 4;

  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/patch_streamer_if.sv
// Output beat stream of the patch streamer: valid/ready plus pixel and position tags.
interface patch_streamer_if #(
  parameter int PIX_W   = 24,
  parameter int PATCH_W = 4,
  parameter int POS_W   = 4
) ();
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pixel;
  logic [PATCH_W-1:0] out_patch_idx;
  logic [POS_W-1:0]   out_pos_idx;
  logic               out_last_pos;
  logic               out_last_patch;

  modport master (
    output out_valid, out_pixel, out_patch_idx, out_pos_idx, out_last_pos, out_last_patch,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_pixel, out_patch_idx, out_pos_idx, out_last_pos, out_last_patch,
    output out_ready
  );
endinterface

// File: rtl/patch_addr_gen.sv
// Maps (patch p, position k) to image coordinates (x, y) for patch-major traversal.
module patch_addr_gen #(
  parameter int IMG_WIDTH  = 16,
  parameter int PATCH_SIZE = 4,
  parameter int PW         = 4,
  parameter int KW         = 4,
  parameter int XW         = 4,
  parameter int YW         = 4
) (
  input  logic [PW-1:0] p,
  input  logic [KW-1:0] k,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);
  localparam int PIR = IMG_WIDTH / PATCH_SIZE;

  int pr, pc, r, c;

  always_comb begin
    pr = int'(p) / PIR;
    pc = int'(p) % PIR;
    r  = int'(k) / PATCH_SIZE;
    c  = int'(k) % PATCH_SIZE;
    x  = XW'(pc * PATCH_SIZE + c);
    y  = YW'(pr * PATCH_SIZE + r);
  end
endmodule

// File: rtl/patch_streamer.sv
// Streams a held pixel frame out one pixel per beat in patch-major order, then
// pulses frame_taken so upstream may replace the frame.
module patch_streamer #(
  parameter int CHANNEL_SIZE = vit_pkg::CHANNEL_SIZE,
  parameter int NUM_CHANNELS = vit_pkg::NUM_CHANNELS,
  parameter int IMG_WIDTH    = vit_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT   = vit_pkg::IMG_HEIGHT,
  parameter int PATCH_SIZE   = vit_pkg::PATCH_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 frame_valid,
  input  logic [CHANNEL_SIZE*NUM_CHANNELS-1:0] all_patches [IMG_WIDTH][IMG_HEIGHT],
  output logic                                 frame_taken,
  output logic [1:0]                           state,
  patch_streamer_if.master                     o
);
  import vit_pkg::state_t;
  import vit_pkg::IDLE;
  import vit_pkg::STREAM;
  import vit_pkg::RELEASE;

  localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;
  localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
  localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;
  localparam int PW = $clog2(TOTAL_NUM_PATCHES);
  localparam int KW = $clog2(PATCH_VECTOR_SIZE);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  state_t                 state_q, state_d;
  logic [PW-1:0]          p_q, p_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   valid_q, valid_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic                   last_pos_q, last_pos_d;
  logic                   last_patch_q, last_patch_d;
  logic                   taken_q, taken_d;
  logic                   hs, final_hs, load;
  logic [XW-1:0]          ax;
  logic [YW-1:0]          ay;

  assign hs       = valid_q & o.out_ready;
  assign final_hs = hs & last_pos_q & last_patch_q;

  // Address generator looks at the *next* (p,k) so the pixel lands with its tags.
  patch_addr_gen #(
    .IMG_WIDTH(IMG_WIDTH), .PATCH_SIZE(PATCH_SIZE),
    .PW(PW), .KW(KW), .XW(XW), .YW(YW)
  ) u_addr (
    .p(p_d), .k(k_d), .x(ax), .y(ay)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_valid) state_d = STREAM;
      STREAM:  if (final_hs)    state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_d     = p_q;
    k_d     = k_q;
    valid_d = valid_q;
    taken_d = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: if (frame_valid) begin
        p_d     = '0;
        k_d     = '0;
        valid_d = 1'b1;
        load    = 1'b1;
      end
      STREAM: if (final_hs) begin
        p_d     = '0;
        k_d     = '0;
        valid_d = 1'b0;
        taken_d = 1'b1;
      end else if (hs) begin
        load = 1'b1;
        if (k_q == KW'(PATCH_VECTOR_SIZE - 1)) begin
          k_d = '0;
          p_d = p_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: valid_d = 1'b0;
    endcase
    pixel_d      = load ? all_patches[ax][ay] : pixel_q;
    last_pos_d   = valid_d & (k_d == KW'(PATCH_VECTOR_SIZE - 1));
    last_patch_d = valid_d & (p_d == PW'(TOTAL_NUM_PATCHES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q          <= '0;
      k_q          <= '0;
      valid_q      <= 1'b0;
      pixel_q      <= '0;
      last_pos_q   <= 1'b0;
      last_patch_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      p_q          <= p_d;
      k_q          <= k_d;
      valid_q      <= valid_d;
      pixel_q      <= pixel_d;
      last_pos_q   <= last_pos_d;
      last_patch_q <= last_patch_d;
      taken_q      <= taken_d;
    end
  end

  assign o.out_valid      = valid_q;
  assign o.out_pixel      = pixel_q;
  assign o.out_patch_idx  = p_q;
  assign o.out_pos_idx    = k_q;
  assign o.out_last_pos   = last_pos_q;
  assign o.out_last_patch = last_patch_q;
  assign frame_taken      = taken_q;
  assign state            = state_q;
endmodule

// File: tb/tb_patch_streamer.sv
// Directed bench for patch_streamer on a 16x16 image with pixel[x][y] = x*16+y.
module tb_patch_streamer;
  logic        clk = 1'b0;
  logic        reset;
  logic        frame_valid;
  logic [23:0] img [16][16];
  logic        frame_taken;
  logic [1:0]  state;
  int          vectors = 0;
  int          miscompares = 0;

  patch_streamer_if bus ();

  patch_streamer dut (
    .clk(clk), .reset(reset), .frame_valid(frame_valid), .all_patches(img),
    .frame_taken(frame_taken), .state(state), .o(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Patch-major reference: beat b -> patch p, position k -> pixel at (x,y).
  function automatic int exp_pix(input int b);
    int p, k, x, y;
    p = b / 16;
    k = b % 16;
    x = (p % 4) * 4 + (k % 4);
    y = (p / 4) * 4 + (k / 4);
    return x * 16 + y;
  endfunction

  // mode 0: ready=1; 1: stall 3 cycles at beat 17; 2: random ready; 3: frame_valid held.
  task automatic run_frame(input int mode);
    int cyc, nb, beats, taken, stall;
    bit done;
    cyc = 0; nb = 0; beats = 0; taken = 0; stall = 0; done = 0;
    frame_valid = 1'b1;
    bus.out_ready = 1'b1;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (mode != 3) frame_valid = 1'b0;
      if (cyc == 1) chk("latency_valid", bus.out_valid, 1);
      if (bus.out_valid) begin
        chk("pixel", bus.out_pixel, exp_pix(nb));
        chk("patch_idx", bus.out_patch_idx, nb / 16);
        chk("pos_idx", bus.out_pos_idx, nb % 16);
        chk("last_pos", bus.out_last_pos, (nb % 16) == 15);
        chk("last_patch", bus.out_last_patch, nb >= 240);
      end else begin
        chk("flags_when_idle", {bus.out_last_pos, bus.out_last_patch}, 0);
      end
      if ((mode == 0 || mode == 3) && cyc <= 258) begin
        chk("valid_window", bus.out_valid, (cyc >= 1 && cyc <= 256));
        chk("taken_window", frame_taken, cyc == 257);
      end
      if (frame_taken) begin
        taken++;
        chk("state_release", state, 2);
        beats = nb;
        nb = 0;
        if (mode != 3) done = 1;
      end
      case (mode)
        1: if (bus.out_valid && nb == 17 && stall < 3) begin
             bus.out_ready = 1'b0;
             stall++;
             chk("stall_pixel", bus.out_pixel, 24'h50);
             chk("stall_patch", bus.out_patch_idx, 1);
             chk("stall_pos", bus.out_pos_idx, 1);
           end else bus.out_ready = 1'b1;
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      if (bus.out_valid && bus.out_ready) nb++;
      if (mode == 3 && cyc == 258) begin
        chk("rearm_idle_state", state, 0);
      end
      if (mode == 3 && cyc == 259) begin
        chk("restart_valid", bus.out_valid, 1);
        chk("restart_pixel", bus.out_pixel, 0);
        chk("restart_patch", bus.out_patch_idx, 0);
        done = 1;
      end
    end
    if (!done) chk("timeout", 0, 1);
    chk("beat_count", beats, 256);
    chk("taken_once", taken, 1);
    if (mode == 1) chk("stall_cycles", stall, 3);
  endtask

  initial begin
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        img[x][y] = 24'(x * 16 + y);
    reset = 1'b1;
    frame_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_state", state, 0);
    chk("rst_taken", frame_taken, 0);
    chk("rst_pixel", bus.out_pixel, 0);
    chk("rst_idx", {bus.out_patch_idx, bus.out_pos_idx}, 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_frame", state, 0);
    chk("ready_no_effect", bus.out_valid, 0);

    run_frame(0);
    @(posedge clk); #1;
    chk("back_to_idle", state, 0);

    run_frame(1);
    @(posedge clk); #1;

    // Reset mid-stream at beat 100.
    frame_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("beat100_pixel", bus.out_pixel, exp_pix(100));
    reset = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_state", state, 0);
    chk("midrst_pixel", bus.out_pixel, 0);
    chk("midrst_flags", {bus.out_last_pos, bus.out_last_patch, frame_taken}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", state, 0);
    chk("post_rst_novalid", bus.out_valid, 0);
    run_frame(0);
    @(posedge clk); #1;

    run_frame(2);
    @(posedge clk); #1;

    run_frame(3);
    frame_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("final_rst_valid", bus.out_valid, 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/patch_streamer.md
PATCH_STREAMER -- requirements
Module: patch_streamer

Interface
REQ-001 Parameters, one per line (name, default, meaning) SHALL be:
- CHANNEL_SIZE, 8, bits per channel.
- NUM_CHANNELS, 3, channels per pixel.
- IMG_WIDTH, 16, pixels per row (x).
- IMG_HEIGHT, 16, pixel rows (y).
- PATCH_SIZE, 4, patch edge in pixels.
REQ-002 Derived constants SHALL be:
- PIXEL_WIDTH = CHANNEL_SIZE*NUM_CHANNELS.
- PATCHES_IN_ROW = IMG_WIDTH/PATCH_SIZE.
- TOTAL_NUM_PATCHES = (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE).
- PATCH_VECTOR_SIZE = PATCH_SIZE*PATCH_SIZE.
REQ-003 Ports, one per line (name, direction, width, meaning) SHALL be; clocking is fixed as one clock, reset asynchronous and active-high:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- frame_valid  in  1  patch array valid and held stable.
- all_patches  in  PIXEL_WIDTH x [IMG_WIDTH][IMG_HEIGHT]  pixel array, indexed [x][y].
- frame_taken  out  1  one-cycle pulse: frame fully consumed.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_pixel  out  PIXEL_WIDTH  current pixel.
- out_patch_idx  out  clog2(TOTAL_NUM_PATCHES)  patch number.
- out_pos_idx  out  clog2(PATCH_VECTOR_SIZE)  position within patch.
- out_last_pos  out  1  final position of a patch.
- out_last_patch  out  1  beat belongs to final patch.
- state  out  2  FSM state.

Function
REQ-004 FSM SHALL have states IDLE=0, STREAM=1, RELEASE=2.
REQ-005 Transitions SHALL be:
- IDLE -> STREAM when frame_valid=1.
- STREAM -> RELEASE on handshake (out_valid & out_ready) of the final beat.
- RELEASE -> IDLE unconditionally after one cycle.
REQ-006 Order SHALL be patch-major: patch p = pr*PATCHES_IN_ROW + pc; position k = r*PATCH_SIZE + c; out_pixel = all_patches[pc*PATCH_SIZE+c][pr*PATCH_SIZE+r].
REQ-007 The cycle after frame_valid is sampled in IDLE, out_valid SHALL be 1 carrying p=0, k=0 (latency 1).
REQ-008 All out_* signals SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-009 Each handshake SHALL advance k; on k wrap (PATCH_SIZE*PATCH_SIZE-1 -> 0) p SHALL increment; the next beat SHALL appear in the following cycle with no bubble.
REQ-010 out_last_pos SHALL equal (k==PATCH_VECTOR_SIZE-1); out_last_patch SHALL equal (p==TOTAL_NUM_PATCHES-1); both SHALL be 0 when out_valid=0.
REQ-011 After the final handshake, out_valid SHALL drop to 0 in RELEASE, and frame_taken SHALL be 1 for exactly that cycle.
REQ-012 frame_valid SHALL be ignored in STREAM and RELEASE; a frame still valid when IDLE is re-entered SHALL restart the stream at p=0, k=0.
REQ-013 all_patches SHALL be sampled combinationally at beat load, with no internal frame copy; upstream holds it stable until frame_taken.
REQ-014 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-015 reset SHALL asynchronously force state=IDLE, p=0, k=0, out_valid=0, out_pixel=0, all index/flag outputs 0, and frame_taken=0, including mid-stream.
REQ-016 After reset deassertion, the first stream SHALL begin only on a fresh frame_valid sampled in IDLE.

Structure
REQ-017 A shared package vit_pkg SHALL hold the image/patch parameters, the derived constants, and the state enum.
REQ-018 One sub-module, patch_addr_gen, SHALL map (p,k) to (x,y) combinationally; patch_streamer owns the FSM, counters and output registers.

Verification
All scenarios use all_patches[x][y] = x*16+y on a 16x16 image with 4x4 patches.
REQ-019 out_ready=1, frame_valid asserted cycle 0: beats cycles 1..256; beat 0=0x00, beat 1=0x10, beat 4=0x01, beat 16=0x40, beat 64=0x04, beat 255=0xFF with out_last_pos=out_last_patch=1; frame_taken=1 at cycle 257 only.
REQ-020 out_ready low 3 cycles at beat 17: out_pixel holds 0x50 with out_patch_idx=1, out_pos_idx=1, then resumes; total 256 distinct handshakes.
REQ-021 reset asserted at beat 100: out_valid=0 immediately; state=0; the next frame restarts at 0x00.
REQ-022 frame_valid held high through frame_taken: second stream starts cycle 259 with pixel 0x00, patch 0.
REQ-023 Random out_ready (50%): scoreboard confirms 256 beats in patch-major order, out_last_pos every 16th beat, and exactly one frame_taken.
